// File: rtl/ft245_fifo_bridge.sv
// FT245 parallel FIFO bridge: TX/RX byte queues, strobe timing FSM,
// round-robin read/write arbitration and device reset pulse.
module ft245_fifo_bridge #(
  parameter int TX_DEPTH_LOG2   = 4,
  parameter int RX_DEPTH_LOG2   = 4,
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1,
  parameter int RESET_CYCLES    = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  inout  wire logic [7:0]        Data,
  output logic                   ReadStrobe,
  output logic                   WriteStrobe,
  input  logic                   ReadOK,
  input  logic                   WriteOK,
  output logic                   ResetDev,
  input  logic                   DevResetReq,
  input  logic [7:0]             TxData,
  input  logic                   TxValid,
  output logic                   TxReady,
  output logic [7:0]             RxData,
  output logic                   RxValid,
  input  logic                   RxReady,
  output logic [TX_DEPTH_LOG2:0] TxCount,
  output logic [RX_DEPTH_LOG2:0] RxCount,
  output logic                   Busy
);

  localparam int TXD = 1 << TX_DEPTH_LOG2;
  localparam int RXD = 1 << RX_DEPTH_LOG2;
  localparam int CW  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    RD_STROBE,
    RECOVER,
    DEV_RESET
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_rd_q, last_rd_d;
  logic            hold_q, hold_d;
  logic [7:0]      dout_q, dout_d;

  logic [7:0]               tx_mem [TXD];
  logic [TX_DEPTH_LOG2-1:0] tx_wp_q, tx_rp_q;
  logic [TX_DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]               rx_mem [RXD];
  logic [RX_DEPTH_LOG2-1:0] rx_wp_q, rx_rp_q;
  logic [RX_DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;

  logic tx_push, tx_pop, rx_push, rx_pop;
  logic rd_ok, wr_ok, cnt_done, drive;

  assign TxReady = tx_cnt_q != (TX_DEPTH_LOG2+1)'(TXD);
  assign RxValid = rx_cnt_q != '0;
  assign TxCount = tx_cnt_q;
  assign RxCount = rx_cnt_q;
  assign RxData  = rx_mem[rx_rp_q];

  assign tx_push = TxValid & TxReady;
  assign rx_pop  = RxValid & RxReady;

  assign rd_ok    = ReadOK & (rx_cnt_q != (RX_DEPTH_LOG2+1)'(RXD));
  assign wr_ok    = WriteOK & (tx_cnt_q != '0);
  assign cnt_done = cnt_q == '0;

  assign ReadStrobe  = state_q != RD_STROBE;
  assign WriteStrobe = state_q != WR_STROBE;
  assign ResetDev    = state_q == DEV_RESET;
  assign Busy        = state_q != IDLE;

  // hold_q keeps the byte on the bus for one cycle after WR rises
  assign drive = (state_q == WR_SETUP) | (state_q == WR_STROBE) | hold_q;
  assign Data  = drive ? dout_q : 8'hzz;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    hold_d    = 1'b0;
    dout_d    = dout_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (DevResetReq) begin
          state_d = DEV_RESET;
          cnt_d   = CW'(RESET_CYCLES - 1);
        end else if (rd_ok && (!wr_ok || !last_rd_q)) begin
          state_d   = RD_STROBE;
          cnt_d     = CW'(STROBE_CYCLES - 1);
          last_rd_d = 1'b1;
        end else if (wr_ok) begin
          state_d   = WR_SETUP;
          cnt_d     = CW'(SETUP_CYCLES - 1);
          last_rd_d = 1'b0;
          dout_d    = tx_mem[tx_rp_q];
        end
      end
      WR_SETUP: begin
        if (cnt_done) begin
          state_d = WR_STROBE;
          cnt_d   = CW'(STROBE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_STROBE: begin
        if (cnt_done) begin
          state_d = RECOVER;
          cnt_d   = CW'(RECOVERY_CYCLES - 1);
          tx_pop  = 1'b1;
          hold_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_STROBE: begin
        if (cnt_done) begin
          state_d = RECOVER;
          cnt_d   = CW'(RECOVERY_CYCLES - 1);
          rx_push = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RECOVER, DEV_RESET: begin
        if (cnt_done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    unique case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_rd_q <= 1'b0;
      hold_q    <= 1'b0;
      dout_q    <= '0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
      hold_q    <= hold_d;
      dout_q    <= dout_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (tx_push) tx_mem[tx_wp_q] <= TxData;
    if (rx_push) rx_mem[rx_wp_q] <= Data;
  end

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Scoreboard bench for ft245_fifo_bridge with a simple FT245 device model.
// Undriven bus reads as 8'hFF through a pull-up.
module tb_ft245_fifo_bridge;
  localparam int STB = 2;

  logic       Clock = 1'b0;
  logic       Reset;
  wire  [7:0] Data;
  logic       ReadStrobe, WriteStrobe;
  logic       ReadOK, WriteOK;
  logic       ResetDev, DevResetReq;
  logic [7:0] TxData;
  logic       TxValid, TxReady;
  logic [7:0] RxData;
  logic       RxValid, RxReady;
  logic [4:0] TxCount, RxCount;
  logic       Busy;

  ft245_fifo_bridge dut (
    .Clock(Clock), .Reset(Reset), .Data(Data),
    .ReadStrobe(ReadStrobe), .WriteStrobe(WriteStrobe),
    .ReadOK(ReadOK), .WriteOK(WriteOK),
    .ResetDev(ResetDev), .DevResetReq(DevResetReq),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
    .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .TxCount(TxCount), .RxCount(RxCount), .Busy(Busy)
  );

  pullup (Data);
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  logic [7:0] dev_mem [64];
  int         dev_wr = 0;
  int         dev_rd = 0;
  logic [7:0] dev_byte = 8'hEE;
  logic       rok_en;

  assign ReadOK = rok_en && (dev_rd != dev_wr);
  assign Data   = ReadStrobe ? 8'hzz : dev_byte;

  always @(negedge ReadStrobe) begin
    if (dev_rd != dev_wr) begin
      dev_byte = dev_mem[dev_rd];
      dev_rd   = dev_rd + 1;
    end else begin
      dev_byte = 8'hEE;
    end
  end

  typedef struct packed {
    logic       rd;
    logic [7:0] d;
  } xfer_t;

  xfer_t      exp_q[$];
  logic [7:0] exp_rx[$];
  int         wr_falls[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         rst_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b, input bit expect_wr);
    TxData  = b;
    TxValid = 1'b1;
    tick(1);
    TxValid = 1'b0;
    if (expect_wr) exp_q.push_back('{rd: 1'b0, d: b});
  endtask

  task automatic dev_add(input logic [7:0] b);
    dev_mem[dev_wr] = b;
    dev_wr = dev_wr + 1;
    exp_q.push_back('{rd: 1'b1, d: 8'h00});
    exp_rx.push_back(b);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while ((exp_q.size() != 0 || Busy) && k < 300) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(k < 300), 32'd1);
  endtask

  task automatic monitor();
    logic  pw = 1'b1;
    logic  pr = 1'b1;
    int    wlow = 0;
    logic [7:0] wdat = 8'h00;
    xfer_t e;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        pw = 1'b1; pr = 1'b1; wlow = 0;
        continue;
      end
      if (!ReadStrobe || !WriteStrobe)
        chk("strobe overlap", 32'(ReadStrobe | WriteStrobe), 32'd1);
      if (!WriteStrobe) begin
        if (pw) begin
          wr_falls.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected WR", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("xfer kind", 32'(e.rd), 32'd0);
            wdat = e.d;
          end
        end
        chk("wr data", 32'(Data), 32'(wdat));
        wlow++;
      end else if (!pw) begin
        chk("wr width", 32'(wlow), 32'(STB));
        wlow = 0;
      end
      if (!ReadStrobe) begin
        if (pr) begin
          if (exp_q.size() == 0) begin
            chk("unexpected RD", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("xfer kind", 32'(e.rd), 32'd1);
          end
        end
        chk("rd bus", 32'(Data), 32'(dev_byte));
      end
      if (ResetDev) rst_cyc++;
      if (RxValid && RxReady) begin
        if (exp_rx.size() == 0) chk("unexpected rx pop", 32'd1, 32'd0);
        else chk("rx data", 32'(RxData), 32'(exp_rx.pop_front()));
      end
      pw = WriteStrobe;
      pr = ReadStrobe;
    end
  endtask

  initial begin
    int t0, r0, k;
    Reset = 1'b1; WriteOK = 1'b0; rok_en = 1'b0;
    DevResetReq = 1'b0; TxData = '0; TxValid = 1'b0; RxReady = 1'b0;
    fork
      monitor();
    join_none
    tick(2);
    chk("rst RD#", 32'(ReadStrobe), 32'd1);
    chk("rst WR", 32'(WriteStrobe), 32'd1);
    chk("rst Data", 32'(Data), 32'hFF);
    chk("rst ResetDev", 32'(ResetDev), 32'd0);
    chk("rst Busy", 32'(Busy), 32'd0);
    chk("rst counts", 32'({TxCount, RxCount}), 32'd0);
    chk("rst flags", 32'({TxReady, RxValid}), 32'b10);
    Reset = 1'b0;

    push_tx(8'h11, 1'b1);
    push_tx(8'h22, 1'b1);
    push_tx(8'h33, 1'b1);
    chk("tx count 3", 32'(TxCount), 32'd3);
    WriteOK = 1'b1;
    wait_done("writes done");
    chk("tx count 0", 32'(TxCount), 32'd0);
    chk("wr pulses", 32'(wr_falls.size()), 32'd3);
    if (wr_falls.size() == 3) begin
      chk("wr period 1", 32'(wr_falls[1] - wr_falls[0]), 32'd5);
      chk("wr period 2", 32'(wr_falls[2] - wr_falls[1]), 32'd5);
    end

    WriteOK = 1'b0;
    wr_falls.delete();
    push_tx(8'h44, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("wr idle strobe", 32'(WriteStrobe), 32'd1);
      chk("wr idle bus", 32'(Data), 32'hFF);
    end
    t0 = cyc;
    WriteOK = 1'b1;
    wait_done("late write");
    chk("late wr pulses", 32'(wr_falls.size()), 32'd1);
    if (wr_falls.size() == 1)
      chk("wr latency", 32'(wr_falls[0] - t0), 32'd2);
    WriteOK = 1'b0;

    dev_add(8'hA5);
    dev_add(8'h5A);
    for (int i = 0; i < 15; i++) dev_add(8'(8'h10 + i));
    rok_en = 1'b1;
    k = 0;
    while (RxCount != 5'd2 && k < 100) begin tick(1); k++; end
    chk("rx 2 bound", 32'(k < 100), 32'd1);
    chk("rx valid", 32'(RxValid), 32'd1);
    chk("rx head", 32'(RxData), 32'hA5);
    k = 0;
    while (RxCount != 5'd16 && k < 200) begin tick(1); k++; end
    chk("rx full bound", 32'(k < 200), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("full RD# high", 32'(ReadStrobe), 32'd1);
    end
    chk("rx count 16", 32'(RxCount), 32'd16);
    chk("read pending", 32'(exp_q.size()), 32'd1);
    RxReady = 1'b1;
    tick(1);
    RxReady = 1'b0;
    wait_done("read resume");
    chk("rx refill", 32'(RxCount), 32'd16);
    RxReady = 1'b1;
    k = 0;
    while (RxValid && k < 100) begin tick(1); k++; end
    RxReady = 1'b0;
    chk("rx drained", 32'(exp_rx.size()), 32'd0);
    rok_en = 1'b0;

    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    exp_rx.delete();
    exp_q.delete();
    for (int i = 1; i <= 4; i++) begin
      dev_add(8'(8'hC0 + i));
      push_tx(8'(i), 1'b1);
    end
    RxReady = 1'b1;
    WriteOK = 1'b1;
    rok_en  = 1'b1;
    wait_done("round robin");
    tick(2);
    chk("rr tx empty", 32'(TxCount), 32'd0);
    chk("rr rx empty", 32'(RxCount), 32'd0);
    chk("rr rx all", 32'(exp_rx.size()), 32'd0);
    WriteOK = 1'b0;
    RxReady = 1'b0;

    push_tx(8'h66, 1'b0);
    push_tx(8'h77, 1'b0);
    dev_add(8'h3C);
    wait_done("one read");
    rok_en = 1'b0;
    chk("pre dev tx", 32'(TxCount), 32'd2);
    chk("pre dev rx", 32'(RxCount), 32'd1);
    r0 = rst_cyc;
    DevResetReq = 1'b1;
    tick(1);
    DevResetReq = 1'b0;
    tick(8);
    chk("ResetDev len", 32'(rst_cyc - r0), 32'd4);
    chk("dev tx kept", 32'(TxCount), 32'd2);
    chk("dev rx kept", 32'(RxCount), 32'd1);
    chk("dev busy", 32'(Busy), 32'd0);

    exp_q.push_back('{rd: 1'b0, d: 8'h66});
    WriteOK = 1'b1;
    tick(3);
    chk("mid strobe", 32'(WriteStrobe), 32'd0);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    exp_rx.delete();
    chk("abort WR", 32'(WriteStrobe), 32'd1);
    chk("abort Data", 32'(Data), 32'hFF);
    chk("abort counts", 32'({TxCount, RxCount}), 32'd0);
    chk("abort Busy", 32'(Busy), 32'd0);
    WriteOK = 1'b0;
    tick(3);
    chk("no stray xfer", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
